// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// Time-setting controller for the real-time clock. Debounces the mode and
// increment buttons, steps RUN -> SET_HR -> SET_MIN -> RUN on mode presses,
// and issues single-cycle increment pulses with auto-repeat to the hour/minute
// datapath. Also drives run-enable, a seconds-clear pulse, blink masks for the
// digit being set and a synchronized fast-test level.
//
// Ports:
//   clk_i        system clock (100 MHz)
//   rst_i        asynchronous active-low reset
//   btn_mode_i   raw mode button (async, active-high)
//   btn_inc_i    raw increment button (async, active-high)
//   btn_test_i   raw fast-test button (async, active-high)
//   mode_o       00 RUN, 01 SET_HR, 10 SET_MIN
//   run_en_o     counter may advance (high only in RUN)
//   inc_hr_o     one-cycle hour increment pulse
//   inc_min_o    one-cycle minute increment pulse
//   sec_clr_o    one-cycle seconds/prescaler clear pulse
//   blank_hr_o   blank hour digits (blink)
//   blank_min_o  blank minute digits (blink)
//   fast_o       synchronized test level
module time_set_ctrl #(
  parameter int unsigned DEB_CYCLES     = 32'd1_000_000,
  parameter int unsigned REPEAT_DELAY   = 32'd50_000_000,
  parameter int unsigned REPEAT_RATE    = 32'd10_000_000,
  parameter int unsigned BLINK_HALF     = 32'd25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic       btn_test_i,
  output logic [1:0] mode_o,
  output logic       run_en_o,
  output logic       inc_hr_o,
  output logic       inc_min_o,
  output logic       sec_clr_o,
  output logic       blank_hr_o,
  output logic       blank_min_o,
  output logic       fast_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  localparam logic [31:0] DEB_LAST   = DEB_CYCLES - 32'd1;
  localparam logic [31:0] DELAY_LAST = REPEAT_DELAY - 32'd1;
  localparam logic [31:0] RATE_LAST  = REPEAT_RATE - 32'd1;
  localparam logic [31:0] BLINK_LAST = BLINK_HALF - 32'd1;
  localparam logic [31:0] TMO_LAST   = TIMEOUT_CYCLES - 32'd1;

  // Button bit order in the synchronizer: [0] mode, [1] inc, [2] test.
  logic [2:0]  r_sync1, r_sync2;
  logic [1:0]  r_deb, r_deb_prev;
  logic [31:0] r_deb_cnt [2];

  state_t      r_state, w_state_nxt;
  logic        r_run_en, r_inc_hr, r_inc_min, r_sec_clr, r_blank_hr, r_blank_min;
  logic [31:0] r_rep_cnt, w_rep_cnt_nxt;
  logic        r_rep_arm, w_rep_arm_nxt, r_rep_first, w_rep_first_nxt;
  logic [31:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [31:0] r_blink_cnt, w_blink_cnt_nxt;
  logic        r_phase, w_phase_nxt;
  logic        w_mode_ev, w_inc_ev, w_rep_fire, w_idle_to;
  logic        w_pulse, w_sec_clr_nxt, w_chg;

  assign w_mode_ev  = r_deb[0] & ~r_deb_prev[0];
  assign w_inc_ev   = r_deb[1] & ~r_deb_prev[1];
  // The first repeat waits the long delay, later ones the short rate.
  assign w_rep_fire = r_rep_arm & r_deb[1] &
                      (r_rep_first ? (r_rep_cnt == DELAY_LAST) : (r_rep_cnt == RATE_LAST));
  assign w_idle_to  = (r_idle_cnt == TMO_LAST);
  assign w_chg      = (w_state_nxt != r_state);

  // Two-flop synchronizers for all three buttons.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {btn_test_i, btn_inc_i, btn_mode_i};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce mode and inc: accept a new level after DEB_CYCLES stable samples.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_deb        <= 2'b00;
      r_deb_prev   <= 2'b00;
      r_deb_cnt[0] <= 32'd0;
      r_deb_cnt[1] <= 32'd0;
    end else begin
      r_deb_prev <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= 32'd0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= 32'd0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 32'd1;
        end
      end
    end
  end

  // Next-state decode: a mode event beats an inc event, and any pulse beats the timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_pulse       = 1'b0;
    w_sec_clr_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mode_ev) w_state_nxt = ST_SET_HR;
        else           w_state_nxt = ST_RUN;
      end
      ST_SET_HR: begin
        if (w_mode_ev)                    w_state_nxt = ST_SET_MIN;
        else if (w_inc_ev || w_rep_fire)  w_pulse = 1'b1;
        else if (w_idle_to)               w_state_nxt = ST_RUN;
        else                              w_state_nxt = ST_SET_HR;
      end
      ST_SET_MIN: begin
        if (w_mode_ev) begin
          w_state_nxt   = ST_RUN;
          w_sec_clr_nxt = 1'b1;
        end else if (w_inc_ev || w_rep_fire) begin
          w_pulse = 1'b1;
        end else if (w_idle_to) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_SET_MIN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Auto-repeat tracking: armed only by an accepted inc event, so an inc held
  // across a mode change stays silent until it is released and pressed again.
  always_comb begin
    w_rep_arm_nxt   = r_rep_arm;
    w_rep_first_nxt = r_rep_first;
    w_rep_cnt_nxt   = r_rep_cnt;
    if (w_chg || !r_deb[1]) begin
      w_rep_arm_nxt   = 1'b0;
      w_rep_first_nxt = 1'b0;
      w_rep_cnt_nxt   = 32'd0;
    end else if (w_pulse && w_inc_ev) begin
      w_rep_arm_nxt   = 1'b1;
      w_rep_first_nxt = 1'b1;
      w_rep_cnt_nxt   = 32'd0;
    end else if (w_rep_fire) begin
      w_rep_first_nxt = 1'b0;
      w_rep_cnt_nxt   = 32'd0;
    end else if (r_rep_arm) begin
      w_rep_cnt_nxt   = r_rep_cnt + 32'd1;
    end else begin
      w_rep_cnt_nxt   = 32'd0;
    end
  end

  // Idle timeout and blink phase counters.
  always_comb begin
    w_idle_cnt_nxt  = r_idle_cnt;
    w_blink_cnt_nxt = r_blink_cnt;
    w_phase_nxt     = r_phase;
    if (w_chg || w_mode_ev || w_pulse) w_idle_cnt_nxt = 32'd0;
    else if (r_state != ST_RUN)        w_idle_cnt_nxt = r_idle_cnt + 32'd1;
    else                               w_idle_cnt_nxt = 32'd0;
    // Restart blink as "visible" so the user sees the value just changed.
    if (w_chg || w_pulse) begin
      w_blink_cnt_nxt = 32'd0;
      w_phase_nxt     = 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      w_blink_cnt_nxt = 32'd0;
      w_phase_nxt     = ~r_phase;
    end else begin
      w_blink_cnt_nxt = r_blink_cnt + 32'd1;
    end
  end

  // State, registered outputs and counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_RUN;
      r_run_en    <= 1'b1;
      r_inc_hr    <= 1'b0;
      r_inc_min   <= 1'b0;
      r_sec_clr   <= 1'b0;
      r_blank_hr  <= 1'b0;
      r_blank_min <= 1'b0;
      r_rep_cnt   <= 32'd0;
      r_rep_arm   <= 1'b0;
      r_rep_first <= 1'b0;
      r_idle_cnt  <= 32'd0;
      r_blink_cnt <= 32'd0;
      r_phase     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_run_en    <= (w_state_nxt == ST_RUN);
      r_inc_hr    <= w_pulse & (r_state == ST_SET_HR);
      r_inc_min   <= w_pulse & (r_state == ST_SET_MIN);
      r_sec_clr   <= w_sec_clr_nxt;
      r_blank_hr  <= (w_state_nxt == ST_SET_HR) & w_phase_nxt;
      r_blank_min <= (w_state_nxt == ST_SET_MIN) & w_phase_nxt;
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_arm   <= w_rep_arm_nxt;
      r_rep_first <= w_rep_first_nxt;
      r_idle_cnt  <= w_idle_cnt_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase     <= w_phase_nxt;
    end
  end

  assign mode_o      = r_state;
  assign run_en_o    = r_run_en;
  assign inc_hr_o    = r_inc_hr;
  assign inc_min_o   = r_inc_min;
  assign sec_clr_o   = r_sec_clr;
  assign blank_hr_o  = r_blank_hr;
  assign blank_min_o = r_blank_min;
  assign fast_o      = r_sync2[2];

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-setting controller for the real-time clock: it debounces the user buttons, runs the RUN / SET_HR / SET_MIN mode state machine and issues single-cycle increment pulses, with auto-repeat, to the hour/minute counting datapath. It also produces run-enable, seconds-clear, display blink masks and a synchronized fast-test level. It sits between the board buttons and the counter/display blocks, in the `clk_i` (100 MHz) domain.

## Interface
- DEB_CYCLES, 1_000_000, cycles a synchronized button level must be stable before it is accepted (10 ms).
- REPEAT_DELAY, 50_000_000, cycles from the first increment pulse to the first auto-repeat pulse.
- REPEAT_RATE, 10_000_000, cycles between subsequent auto-repeat pulses.
- BLINK_HALF, 25_000_000, cycles per blink half-period.
- TIMEOUT_CYCLES, 1_000_000_000, idle cycles in a SET mode before returning to RUN.
- clk_i  in  1  system clock, 100 MHz.
- rst_i  in  1  reset, asynchronous, active-low.
- btn_mode_i  in  1  raw mode button, asynchronous, active-high.
- btn_inc_i  in  1  raw increment button, asynchronous, active-high.
- btn_test_i  in  1  raw fast-test button, asynchronous, active-high.
- mode_o  out  2  00 = RUN, 01 = SET_HR, 10 = SET_MIN; 11 is never driven.
- run_en_o  out  1  counter may advance; high only in RUN.
- inc_hr_o  out  1  one-cycle pulse: increment hours.
- inc_min_o  out  1  one-cycle pulse: increment minutes.
- sec_clr_o  out  1  one-cycle pulse: clear seconds/prescaler.
- blank_hr_o  out  1  blank hour digits (blink).
- blank_min_o  out  1  blank minute digits (blink).
- fast_o  out  1  synchronized test level, selects the fast divider.

## Operation
- Reset values: state RUN, mode_o=00, run_en_o=1, all pulses 0, blank_*=0, fast_o=0. All counters are 0, debounced levels 0 and blink phase is "visible".
- Each button passes through a 2-FF synchronizer. fast_o is the synchronized btn_test_i level, with no debounce.
- Debounce (mode and inc, independent):
  - A 32-bit counter counts while the synchronized level differs from the debounced level.
  - The counter clears whenever the two are equal.
  - When the count reaches DEB_CYCLES-1 with the levels still differing, the debounced level takes the new value and the counter clears.
  - An event is the rising edge of the debounced level.
- FSM transitions:
  - On a mode event: RUN→SET_HR, SET_HR→SET_MIN, SET_MIN→RUN.
  - SET_MIN→RUN via the mode event pulses sec_clr_o in the same cycle that mode_o changes.
  - In a SET state with no mode or inc event for TIMEOUT_CYCLES cycles: go to RUN with no sec_clr_o pulse.
- Increment:
  - In SET_HR, an inc event pulses inc_hr_o; in SET_MIN, it pulses inc_min_o.
  - In RUN, inc events are ignored.
- Auto-repeat:
  - While the debounced inc level stays high in a SET state, a further pulse is issued REPEAT_DELAY cycles after the first, then every REPEAT_RATE cycles.
  - Release, or any mode change, clears the repeat counter. A held inc across a mode change produces no pulse in the new mode until it is released and pressed again.
- Simultaneous mode and inc events: mode wins and the inc event is dropped.
- Blink:
  - A free-running counter toggles the phase every BLINK_HALF cycles.
  - The phase and counter reset to "visible" on every mode change and every inc pulse.
  - blank_hr_o = SET_HR & phase hidden; blank_min_o = SET_MIN & phase hidden.
- The idle timeout counter clears on every mode event, inc pulse (including repeats) and mode change.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Button latency: if raw goes high and is first sampled at edge k and stays stable, the debounced level rises at edge k+DEB_CYCLES+1. The resulting inc/mode effect (pulse or mode_o change) is visible after edge k+DEB_CYCLES+2.
- Glitches shorter than DEB_CYCLES cycles produce no event.
- Pulses are exactly one cycle wide. Two pulses are never asserted together: inc_hr_o, inc_min_o and sec_clr_o are mutually exclusive.
- run_en_o changes in the same cycle as mode_o.
- Reset mid-operation: all outputs return to reset values asynchronously, with no pulse emitted. After release, a button held through reset must be debounced afresh before any event.
- Counter widths are 32 bits. Parameters must be ≥2, and counters never wrap within a count period.

## Test plan
All scenarios use DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, BLINK_HALF=10, TIMEOUT_CYCLES=100.

- Mode cycle: three clean mode presses → mode_o goes 01, 10, 00. run_en_o is low only in 01/10. sec_clr_o pulses once, on the 10→00 step. Each change occurs DEB_CYCLES+2 edges after first sampling.
- Debounce: a 3-cycle glitch on btn_mode_i produces no change; the same pulse held 6 cycles produces exactly one mode change.
- Auto-repeat: in SET_HR, hold inc for 60 cycles after its first pulse → inc_hr_o pulses at relative cycles 0, 20, 28, 36, 44, 52 and nowhere else; inc_min_o stays 0.
- Simultaneous events: mode and inc rise on the same edge in SET_HR → mode_o goes to 10 with no inc pulse. Inc in RUN produces no pulse.
- Blink and timeout: enter SET_MIN and idle → blank_min_o toggles every 10 cycles and blank_hr_o stays 0. mode_o returns to 00 after 100 idle cycles, with no sec_clr_o pulse.
- Reset: assert rst_i during an auto-repeat → all outputs return to reset values immediately. With inc held, no pulse occurs after release while mode_o is 00.
